// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit for the 5-stage pipeline.
// Turns EX/MEM load/store requests into single-word data-bus transactions
// (IDLE -> BUSY -> DONE), stalls the upstream stages while the bus is busy,
// and formats load data (lane select plus sign/zero extension) for MEM/WB.
// Optional feature: define MEM_TIMEOUT_EN to bound BUSY to TIMEOUT_CYCLES
// cycles and report an expired wait on bus_err.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic [1:0]  MEM_SIZE,
    input  logic        MEM_Unsigned,
    input  logic [31:0] MEM_ALU_OUT,
    input  logic [31:0] MEM_STORE_DATA,
    input  logic        MEM_RegWrite_in,
    input  logic [4:0]  MEM_RD_in,
    output logic        MEM_RegWrite,
    output logic [31:0] MEM_DATA,
    output logic [4:0]  MEM_RD,
    output logic        mem_stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] load_buf;
    logic        access;
    logic        is_store;
    logic        misaligned_addr;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_fmt;
    logic        to_hit;

    // A zero limit would make every access time out before it could start.
    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // Both request bits high is a store; the read is dropped.
    assign access   = MEM_MemRead | MEM_MemWrite;
    assign is_store = MEM_MemWrite;
    assign MEM_RD   = MEM_RD_in;

    // Byte-lane enables, replicated store data and alignment check per access size.
    always_comb begin
        be_next         = 4'b1111;
        wdata_next      = MEM_STORE_DATA;
        misaligned_addr = 1'b0;
        case (MEM_SIZE)
            2'b00: begin
                be_next    = 4'b0001 << MEM_ALU_OUT[1:0];
                wdata_next = {4{MEM_STORE_DATA[7:0]}};
            end
            2'b01: begin
                be_next         = MEM_ALU_OUT[1] ? 4'b1100 : 4'b0011;
                wdata_next      = {2{MEM_STORE_DATA[15:0]}};
                misaligned_addr = MEM_ALU_OUT[0];
            end
            default: begin
                misaligned_addr = (MEM_ALU_OUT[1:0] != 2'b00);
            end
        endcase
    end

    // Lane select and sign/zero extension of the captured read word.
    always_comb begin
        ld_byte  = load_buf[7:0];
        ld_half  = MEM_ALU_OUT[1] ? load_buf[31:16] : load_buf[15:0];
        load_fmt = load_buf;
        case (MEM_ALU_OUT[1:0])
            2'b00:   ld_byte = load_buf[7:0];
            2'b01:   ld_byte = load_buf[15:8];
            2'b10:   ld_byte = load_buf[23:16];
            default: ld_byte = load_buf[31:24];
        endcase
        case (MEM_SIZE)
            2'b00:   load_fmt = {{24{~MEM_Unsigned & ld_byte[7]}}, ld_byte};
            2'b01:   load_fmt = {{16{~MEM_Unsigned & ld_half[15]}}, ld_half};
            default: load_fmt = load_buf;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] to_cnt;

    // The counter holds the number of BUSY cycles already spent without ready.
    assign to_hit = (to_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Bus-wait counter and a one-cycle bus_err pulse covering the DONE cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            to_cnt  <= '0;
            bus_err <= 1'b0;
        end else begin
            bus_err <= (state == BUSY) && !dmem_ready && to_hit;
            if (state == BUSY)
                to_cnt <= to_cnt + 1'b1;
            else
                to_cnt <= '0;
        end
    end
`else
    assign to_hit  = 1'b0;
    assign bus_err = 1'b0;
`endif

    // Access sequencer: launches the bus request, waits for ready, holds DONE one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            load_buf   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && !misaligned_addr) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_store;
                        dmem_addr  <= {MEM_ALU_OUT[31:2], 2'b00};
                        dmem_be    <= be_next;
                        dmem_wdata <= wdata_next;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (dmem_ready || to_hit) begin
                        if (dmem_ready)
                            load_buf <= dmem_rdata;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        dmem_be  <= '0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Pipeline-facing outputs; writeback is suppressed while stalled or on a fault.
    always_comb begin
        mem_stall    = 1'b0;
        misalign     = 1'b0;
        MEM_DATA     = MEM_ALU_OUT;
        MEM_RegWrite = MEM_RegWrite_in;
        case (state)
            IDLE: begin
                if (access) begin
                    MEM_RegWrite = 1'b0;
                    if (misaligned_addr)
                        misalign = 1'b1;
                    else
                        mem_stall = 1'b1;
                end
            end
            BUSY: begin
                mem_stall    = 1'b1;
                MEM_RegWrite = 1'b0;
            end
            DONE: begin
                if (!is_store)
                    MEM_DATA = load_fmt;
                if (bus_err)
                    MEM_RegWrite = 1'b0;
            end
            default: begin
                mem_stall = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the bus-wait cycle limit (used only with MEM_TIMEOUT_EN).
REQ-002 clock  in  1  clock; reset  in  1  reset, asynchronous, active-high.
REQ-003 MEM_MemRead  in  1  load request; MEM_MemWrite  in  1  store request.
REQ-004 MEM_SIZE  in  2  00 byte, 01 half, 10 word (11 treated as word); MEM_Unsigned  in  1  zero-extend loads when 1.
REQ-005 MEM_ALU_OUT  in  32  effective address / ALU result; MEM_STORE_DATA  in  32  store data (rt).
REQ-006 MEM_RegWrite_in  in  1, MEM_RD_in  in  5  writeback control from EX/MEM register.
REQ-007 MEM_RegWrite  out  1, MEM_DATA  out  32, MEM_RD  out  5  feed MEM/WB register.
REQ-008 mem_stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM while high.
REQ-009 misalign  out  1  misaligned-access flag; bus_err  out  1  timeout flag.
REQ-010 dmem_req  out  1, dmem_we  out  1, dmem_addr  out  32 (word-aligned, [1:0]=0), dmem_be  out  4, dmem_wdata  out  32, all registered.
REQ-011 dmem_ready  in  1  access complete; dmem_rdata  in  32  read word, valid when dmem_ready=1.

Function
REQ-012 Block SHALL implement FSM states IDLE, BUSY, DONE; upstream inputs are held stable while mem_stall=1.
REQ-013 Access = MEM_MemRead | MEM_MemWrite; both high SHALL be treated as store, read ignored.
REQ-014 Misaligned: half with addr[0]=1, word with addr[1:0]!=0; in IDLE SHALL assert misalign combinationally, issue no bus request, keep mem_stall=0, force MEM_RegWrite=0.
REQ-015 IDLE, no access: MEM_DATA=MEM_ALU_OUT, MEM_RegWrite=MEM_RegWrite_in, MEM_RD=MEM_RD_in combinationally, mem_stall=0.
REQ-016 IDLE, aligned access: mem_stall=1 combinationally; next edge loads dmem_* registers, sets dmem_req=1, enters BUSY.
REQ-017 BUSY: mem_stall=1, dmem_req held 1 with stable addr/be/wdata; edge with dmem_ready=1 SHALL capture dmem_rdata into load buffer, clear dmem_req, enter DONE.
REQ-018 DONE: mem_stall=0 for exactly one cycle; next edge returns to IDLE (MEM/WB captures results on that edge).
REQ-019 DONE outputs: load -> MEM_DATA = formatted load buffer, MEM_RegWrite=MEM_RegWrite_in; store -> MEM_DATA=MEM_ALU_OUT, MEM_RegWrite=MEM_RegWrite_in.
REQ-020 Minimum load/store latency SHALL be 2 stall cycles (IDLE-detect, one BUSY with ready), plus one per extra BUSY wait.
REQ-021 Little-endian lanes: byte be=1<<addr[1:0], wdata={4{d[7:0]}}; half be=addr[1]?1100:0011, wdata={2{d[15:0]}}; word be=1111, wdata=d.
REQ-022 Loads: select lane per addr; sign-extend bit 7/15 unless MEM_Unsigned=1; word loads pass unchanged.
REQ-023 dmem_we SHALL be 1 for stores, 0 for loads, for whole BUSY duration; dmem_be=0000 when dmem_req=0.
REQ-024 dmem_ready while not BUSY SHALL be ignored.

Reset
REQ-025 Reset SHALL asynchronously force state IDLE and dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, load buffer, timeout counter, bus_err to 0.
REQ-026 Reset during BUSY SHALL abandon the access; dmem_req drops immediately without waiting for dmem_ready.
REQ-027 After reset release, with no access presented, mem_stall and misalign SHALL read 0.

Configuration
REQ-028 Macro MEM_TIMEOUT_EN defined: counter clears on BUSY entry, increments per BUSY cycle; reaching TIMEOUT_CYCLES without dmem_ready SHALL clear dmem_req, enter DONE, set bus_err=1 for the DONE cycle only, force MEM_RegWrite=0.
REQ-029 Macro undefined: no counter, bus_err tied 0, BUSY waits indefinitely.

Verification
REQ-030 ALU op, RegWrite_in=1, ALU_OUT=0x1234, RD=5 -> MEM_DATA=0x1234, RegWrite=1, RD=5, mem_stall=0, no dmem_req.
REQ-031 LB addr 0x103, rdata=0x80FFFFFF ready first BUSY cycle -> dmem_addr=0x100, be=1000, 2 stall cycles, DONE MEM_DATA=0xFFFFFF80; LBU -> 0x00000080.
REQ-032 SH addr 0x202, data 0xABCD1234, ready after 3 BUSY cycles -> be=1100, wdata=0x12341234, we=1, 4 stall cycles.
REQ-033 LW addr 0x101 -> misalign=1, no dmem_req, mem_stall=0, MEM_RegWrite=0.
REQ-034 Reset asserted on second BUSY cycle of LW -> dmem_req=0 same cycle, state IDLE, mem_stall follows inputs after release.
REQ-035 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, dmem_ready held 0 -> DONE after 4 BUSY cycles, bus_err=1 one cycle, MEM_RegWrite=0.
